// File: rtl/line_code_pkg.sv
// Shared code points and buffer state encoding for the one-hot line encoder
// and its decoder counterpart, so both benches agree on the loop-back mapping.
package line_code_pkg;

    localparam logic [1:0] CODE_W1 = 2'b00;
    localparam logic [1:0] CODE_W2 = 2'b01;
    localparam logic [1:0] CODE_W3 = 2'b10;
    localparam logic [1:0] CODE_W4 = 2'b11;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        logic [1:0] code;
        logic       err;
    } enc_entry_t;

endpackage

// File: rtl/onehot4_enc.sv
// Combinational 4-line priority encoder: highest active line wins, and any
// word that is not exactly one-hot raises err.
module onehot4_enc
    import line_code_pkg::*;
(
    input  logic w1,
    input  logic w2,
    input  logic w3,
    input  logic w4,
    output logic a,
    output logic b,
    output logic err
);

    logic [1:0] code;
    logic [2:0] ones;

    always_comb begin
        if (w4)      code = CODE_W4;
        else if (w3) code = CODE_W3;
        else if (w2) code = CODE_W2;
        else         code = CODE_W1;
    end

    assign ones = {2'b00, w1} + {2'b00, w2} + {2'b00, w3} + {2'b00, w4};
    assign err  = (ones != 3'd1);
    assign a    = code[1];
    assign b    = code[0];

endmodule

// File: rtl/line_encoder_4to2.sv
// Clocked 4-to-2 line encoder: valid/ready input, 2-entry result buffer and a
// saturating count of accepted non-one-hot words.
module line_encoder_4to2
    import line_code_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 w1,
    input  logic                 w2,
    input  logic                 w3,
    input  logic                 w4,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 a,
    output logic                 b,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic [1:0]           state_q, state_d;
    enc_entry_t           head_q, head_d, tail_q, tail_d, new_ent;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 enc_a, enc_b, enc_err;
    logic                 push, pop;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    onehot4_enc u_enc (
        .w1  (w1),
        .w2  (w2),
        .w3  (w3),
        .w4  (w4),
        .a   (enc_a),
        .b   (enc_b),
        .err (enc_err)
    );

    assign new_ent = {enc_a, enc_b, enc_err};

    // in_ready depends only on registered state and rst, never on out_ready.
    assign in_ready  = (state_q != ST_FULL) && !rst;
    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage is not reset, so the head is masked while the buffer is empty.
    assign a         = out_valid & head_q.code[1];
    assign b         = out_valid & head_q.code[0];
    assign out_err   = out_valid & head_q.err;
    assign err_count = cnt_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    head_d  = new_ent;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_d = new_ent;
                end else if (push) begin
                    tail_d  = new_ent;
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (push && new_ent.err) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

endmodule

// File: tb/tb_line_encoder_4to2.sv
// Randomised scoreboard bench for line_encoder_4to2 with a queue-based model;
// a second instance with a 2-bit counter exercises saturation.
module tb_line_encoder_4to2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic       w1 = 1'b0, w2 = 1'b0, w3 = 1'b0, w4 = 1'b0;
    logic       in_ready, out_valid, a, b, out_err;
    logic [7:0] err_count;
    logic       in_ready_s, out_valid_s, a_s, b_s, out_err_s;
    logic [1:0] err_count_s;

    line_encoder_4to2 #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .w1(w1), .w2(w2), .w3(w3), .w4(w4),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .out_err(out_err), .err_count(err_count)
    );

    line_encoder_4to2 #(.ERR_CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .w1(w1), .w2(w2), .w3(w3), .w4(w4),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .a(a_s), .b(b_s), .out_err(out_err_s), .err_count(err_count_s)
    );

    typedef struct {
        int code;
        int err;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend_ent;
    int   total = 0, bad = 0;
    int   cnt8 = 0, cnt2 = 0;
    bit   pend_push = 0, pend_pop = 0, mon_en = 0, fresh = 0;

    // Reference: code is the index of the highest set line, err unless exactly one is set.
    function automatic exp_t ref_enc(input logic [3:0] w);
        exp_t e;
        int   n;
        e.code = 0;
        n      = 0;
        for (int i = 0; i < 4; i++) begin
            if (w[i]) begin
                e.code = i;
                n++;
            end
        end
        e.err = (n != 1) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] w, input logic ordy, input logic r);
        @(negedge clk);
        in_valid         = v;
        {w4, w3, w2, w1} = w;
        out_ready        = ordy;
        rst              = r;
        #1;
        pend_ent  = ref_enc(w);
        pend_push = v && !r && (exp_q.size() < 2);
    endtask

    // Model state advances on the same edge the DUT would act on.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            cnt8  = 0;
            cnt2  = 0;
            fresh = 1;
        end else begin
            if (pend_pop) void'(exp_q.pop_front());
            if (pend_push) begin
                exp_q.push_back(pend_ent);
                fresh = 0;
                if (pend_ent.err != 0) begin
                    if (cnt8 < 255) cnt8++;
                    if (cnt2 < 3) cnt2++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("in_ready", in_ready, (!rst && exp_q.size() < 2));
                chk("out_valid", out_valid, (exp_q.size() > 0));
                if (exp_q.size() > 0) begin
                    chk("code", {a, b}, exp_q[0].code);
                    chk("out_err", out_err, exp_q[0].err);
                end else if (fresh) begin
                    chk("reset_data", {a, b, out_err}, 0);
                end
                chk("err_count", err_count, cnt8);
                chk("err_count_sat", err_count_s, cnt2);
                pend_pop = out_ready && (exp_q.size() > 0);
            end
        end
    end

    initial begin
        logic [3:0] w;
        int         satx[5];
        satx = '{1, 2, 3, 3, 3};

        drive(1'b0, 4'b0000, 1'b0, 1'b1);
        drive(1'b0, 4'b0000, 1'b0, 1'b1);
        mon_en = 1;

        for (int c = 0; c < 4; c++) begin
            w = 4'b0001 << c;
            drive(1'b1, w, 1'b1, 1'b0);
        end
        drive(1'b0, 4'b0000, 1'b1, 1'b0);

        drive(1'b1, 4'b0000, 1'b1, 1'b0);
        drive(1'b1, 4'b1010, 1'b1, 1'b0);
        drive(1'b0, 4'b0000, 1'b1, 1'b0);
        chk("err_two", err_count, 2);

        drive(1'b1, 4'b0010, 1'b0, 1'b0);
        drive(1'b1, 4'b0100, 1'b0, 1'b0);
        drive(1'b1, 4'b1000, 1'b0, 1'b0);
        chk("bp_in_ready", in_ready, 0);
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 4'b0000, 1'b1, 1'b0);

        drive(1'b1, 4'b0001, 1'b0, 1'b0);
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 1'b0, 1'b1);
        drive(1'b0, 4'b0000, 1'b1, 1'b0);
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_count", err_count, 0);
        drive(1'b0, 4'b0000, 1'b1, 1'b0);

        drive(1'b0, 4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'b0000, 1'b1, 1'b0);
            drive(1'b0, 4'b0000, 1'b1, 1'b0);
            chk("sat_seq", err_count_s, satx[i]);
        end

        for (int c = 0; c < 4; c++) begin
            w = 4'b0001 << c;
            drive(1'b1, w, 1'b1, 1'b0);
        end

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 0) w = 4'b0001 << $urandom_range(0, 3);
            else                          w = 4'($urandom);
            drive(1'($urandom), w, ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
        end

        repeat (6) drive(1'b0, 4'b0000, 1'b1, 1'b0);
        chk("drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
